// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types for the MAC result path.
//   pack_state_e : packer state (PK_EMPTY = no half pending, PK_HALF = low
//                  half held and waiting for its partner)
//   pack_word_t  : one output FIFO entry {data, last, half}
//   FFLAG_*      : bit positions of the sticky exception flags {NV,OF,UF,NX}
// ---------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic {
    PK_EMPTY = 1'b0,
    PK_HALF  = 1'b1
  } pack_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        half;
  } pack_word_t;

  localparam int FFLAG_NV = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

endpackage

// File: rtl/mac_sync_fifo.sv
// ---------------------------------------------------------------------------
// mac_sync_fifo
// Synchronous FIFO of pack_word_t entries, first-word-fall-through head.
// Ports:
//   clk_i       in   clock
//   rst_ni      in   synchronous active-low reset (empties the FIFO)
//   push_i      in   write push_data_i (ignored when full)
//   push_data_i in   entry to write
//   pop_i       in   drop head entry (ignored when empty)
//   full_o      out  DEPTH entries stored
//   empty_o     out  no entries stored
//   head_o      out  oldest entry (contents undefined when empty)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module mac_sync_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  pack_word_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output pack_word_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  pack_word_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push = push_i && (r_count != FULL_CNT);
  assign w_pop  = pop_i && (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fp16_result_packer.sv
// ---------------------------------------------------------------------------
// fp16_result_packer
// Packs converted MAC results into 32-bit words: two consecutive FP16 beats
// become {hi, lo}; FP32 beats pass through. Words are queued in an output
// FIFO; exception flags of accepted beats accumulate into sticky fflags.
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   in_valid_i/in_ready_o   input handshake
//   in_data_i, in_mode_i    result and mode (1 = FP16 in [15:0], 0 = FP32)
//   in_last_i               last beat of tile
//   in_of/uf/nv/nx_i        per-beat exception flags
//   out_valid_o/out_ready_i output handshake (FIFO head)
//   out_data_o/last/half    packed word, tile-last marker, lone-half marker
//   flags_clr_i, fflags_o   clear / sticky {NV,OF,UF,NX}
// Optional (define FP16_PACKER_PERF_CNT_EN):
//   perf_words_o            saturating count of FIFO pops
//   perf_flush_o            saturating count of half-word pushes
// ---------------------------------------------------------------------------
module fp16_result_packer
  import mac_pkg::*;
#(
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_mode_i,
  input  logic        in_last_i,
  input  logic        in_of_i,
  input  logic        in_uf_i,
  input  logic        in_nv_i,
  input  logic        in_nx_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic        out_half_o,
  input  logic        flags_clr_i,
  output logic [3:0]  fflags_o
`ifdef FP16_PACKER_PERF_CNT_EN
  ,
  output logic [31:0] perf_words_o,
  output logic [15:0] perf_flush_o
`endif
);

  pack_state_e r_state;
  pack_state_e w_state_nxt;
  logic [15:0] r_lo;
  logic [3:0]  r_fflags;
  logic        w_full;
  logic        w_empty;
  logic        w_flush_stall;
  logic        w_accept;
  logic        w_push;
  logic        w_hold_lo;
  logic        w_pop;
  logic [3:0]  w_beat_flags;
  pack_word_t  w_push_word;
  pack_word_t  w_head;

  // An FP32 beat arriving behind a pending half must first flush that half
  // as its own word, so it is held off for the flush cycle. Full comes from
  // the registered FIFO count, so out_ready_i never reaches in_ready_o.
  assign w_flush_stall = (r_state == PK_HALF) && in_valid_i && !in_mode_i;
  assign in_ready_o    = !w_full && !w_flush_stall;
  assign w_accept      = in_valid_i && in_ready_o;

  always_comb begin
    w_beat_flags           = '0;
    w_beat_flags[FFLAG_NV] = in_nv_i;
    w_beat_flags[FFLAG_OF] = in_of_i;
    w_beat_flags[FFLAG_UF] = in_uf_i;
    w_beat_flags[FFLAG_NX] = in_nx_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= PK_EMPTY;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_lo) r_lo <= in_data_i[15:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PK_EMPTY: if (w_accept && in_mode_i && !in_last_i) w_state_nxt = PK_HALF;
      PK_HALF:  if (w_accept || (w_flush_stall && !w_full)) w_state_nxt = PK_EMPTY;
      default:  w_state_nxt = PK_EMPTY;
    endcase
  end

  always_comb begin
    w_push      = 1'b0;
    w_hold_lo   = 1'b0;
    w_push_word = '0;
    case (r_state)
      PK_EMPTY: begin
        if (w_accept) begin
          if (!in_mode_i) begin
            w_push           = 1'b1;
            w_push_word.data = in_data_i;
            w_push_word.last = in_last_i;
          end else if (in_last_i) begin
            w_push           = 1'b1;
            w_push_word.data = {16'h0000, in_data_i[15:0]};
            w_push_word.last = 1'b1;
            w_push_word.half = 1'b1;
          end else begin
            w_hold_lo = 1'b1;
          end
        end
      end
      PK_HALF: begin
        // Only FP16 beats can be accepted here; FP32 triggers the flush.
        if (w_accept) begin
          w_push           = 1'b1;
          w_push_word.data = {in_data_i[15:0], r_lo};
          w_push_word.last = in_last_i;
        end else if (w_flush_stall && !w_full) begin
          w_push           = 1'b1;
          w_push_word.data = {16'h0000, r_lo};
          w_push_word.half = 1'b1;
        end
      end
      default: ;
    endcase
  end

  mac_sync_fifo #(
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push),
    .push_data_i (w_push_word),
    .pop_i       (w_pop),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .head_o      (w_head)
  );

  // Outputs are gated by valid so an empty FIFO presents all-zero data.
  assign out_valid_o = !w_empty;
  assign w_pop       = out_valid_o && out_ready_i;
  assign out_data_o  = out_valid_o ? w_head.data : 32'h0;
  assign out_last_o  = out_valid_o && w_head.last;
  assign out_half_o  = out_valid_o && w_head.half;

  // A clear coinciding with an accepted beat keeps that beat's flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fflags <= '0;
    end else if (w_accept) begin
      r_fflags <= flags_clr_i ? w_beat_flags : (r_fflags | w_beat_flags);
    end else if (flags_clr_i) begin
      r_fflags <= '0;
    end
  end

  assign fflags_o = r_fflags;

`ifdef FP16_PACKER_PERF_CNT_EN
  logic [31:0] r_perf_words;
  logic [15:0] r_perf_flush;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flags_clr_i) begin
      r_perf_words <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_pop && (r_perf_words != '1)) r_perf_words <= r_perf_words + 32'd1;
      if (w_push && w_push_word.half && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perf_words_o = r_perf_words;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule
